// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready, flush and optional 2-entry skid; latency 1 cycle.
// Backpressure: SKID_EN=1 registers in_ready (deasserts only when skid slot is full); SKID_EN=0 passes out_ready through.
module pipe_stage_skid #(
  parameter int unsigned PAYLOAD_W      = 104,
  parameter bit          SKID_EN        = 1'b1,
  parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  input  logic                 in_wen_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_data_o,
  output logic                 out_wen_o,
  output logic [1:0]           occupancy_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PAYLOAD_W-1:0] main_dat_q, main_dat_d;
  logic [PAYLOAD_W-1:0] skid_dat_q, skid_dat_d;
  logic                 main_wen_q, main_wen_d;
  logic                 skid_wen_q, skid_wen_d;
  logic                 push, pop;

  // State encoding doubles as the held-entry count.
  assign occupancy_o = state_q;
  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = main_dat_q;
  assign out_wen_o   = out_valid_o & main_wen_q;

  always_comb begin
    in_ready_o = 1'b0;
    if (SKID_EN) begin
      in_ready_o = !rst_i && (state_q != ST_SKID);
    end else begin
      in_ready_o = !rst_i && ((state_q == ST_EMPTY) || out_ready_i);
    end
  end

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  always_comb begin
    state_d    = state_q;
    main_dat_d = main_dat_q;
    main_wen_d = main_wen_q;
    skid_dat_d = skid_dat_q;
    skid_wen_d = skid_wen_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          main_dat_d = in_data_i;
          main_wen_d = in_wen_i;
          state_d    = ST_FULL;
        end
      end
      ST_FULL: begin
        if (push && pop) begin
          main_dat_d = in_data_i;
          main_wen_d = in_wen_i;
        end else if (push) begin
          // Only reachable with the skid slot present; without it in_ready follows out_ready.
          if (SKID_EN) begin
            skid_dat_d = in_data_i;
            skid_wen_d = in_wen_i;
            state_d    = ST_SKID;
          end
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (pop) begin
          main_dat_d = skid_dat_q;
          main_wen_d = skid_wen_q;
          state_d    = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_d = ST_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_dat_d = '0;
        main_wen_d = 1'b0;
        skid_dat_d = '0;
        skid_wen_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      main_dat_q <= '0;
      main_wen_q <= 1'b0;
      skid_dat_q <= '0;
      skid_wen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_dat_q <= main_dat_d;
      main_wen_q <= main_wen_d;
      skid_dat_q <= skid_dat_d;
      skid_wen_q <= skid_wen_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: instance a uses the skid buffer, instance b is pass-through ready.
module tb_pipe_stage_skid;
  localparam int W = 104;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_wen, out_ready;
  logic [W-1:0] in_data;

  logic         in_ready_a, out_valid_a, out_wen_a;
  logic [W-1:0] out_data_a;
  logic [1:0]   occ_a;
  logic         in_ready_b, out_valid_b, out_wen_b;
  logic [W-1:0] out_data_b;
  logic [1:0]   occ_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.PAYLOAD_W(W), .SKID_EN(1'b1), .CLEAR_ON_FLUSH(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_a),
    .in_data_i(in_data), .in_wen_i(in_wen), .out_valid_o(out_valid_a), .out_ready_i(out_ready),
    .out_data_o(out_data_a), .out_wen_o(out_wen_a), .occupancy_o(occ_a));

  pipe_stage_skid #(.PAYLOAD_W(W), .SKID_EN(1'b0), .CLEAR_ON_FLUSH(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
    .in_data_i(in_data), .in_wen_i(in_wen), .out_valid_o(out_valid_b), .out_ready_i(out_ready),
    .out_data_o(out_data_b), .out_wen_o(out_wen_b), .occupancy_o(occ_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = W'(12'hABC); in_wen = 1'b1; out_ready = 1'b0;
    #1;
    checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL reset_in_ready_comb: got %b want 0", in_ready_a); end
    tick(); tick();
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_a); end
    checks++; if (out_data_a !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data_a); end
    checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready_a); end
    checks++; if (occ_a !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occ_a); end
    checks++; if (out_wen_a !== 1'b0) begin errors++; $display("FAIL reset_out_wen: got %b want 0", out_wen_a); end
    rst = 1'b0; in_valid = 1'b0; in_wen = 1'b0;
    tick();
    checks++; if (occ_a !== 2'd0) begin errors++; $display("FAIL reset_no_transfer_occ: got %0d want 0", occ_a); end
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready_a); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1; in_valid = 1'b1; in_wen = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_data = W'(i);
      tick();
      checks++; if (out_data_a !== W'(i)) begin errors++; $display("FAIL stream_data_%0d: got %h want %h", i, out_data_a, W'(i)); end
      checks++; if (occ_a !== 2'd1) begin errors++; $display("FAIL stream_occ_%0d: got %0d want 1", i, occ_a); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %b want 0", out_valid_a); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(8'hA1); in_wen = 1'b1;
    tick();
    checks++; if (occ_a !== 2'd1) begin errors++; $display("FAIL skid_occ_full: got %0d want 1", occ_a); end
    in_data = W'(8'hB2); in_wen = 1'b0;
    tick();
    checks++; if (occ_a !== 2'd2) begin errors++; $display("FAIL skid_occ_two: got %0d want 2", occ_a); end
    checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL skid_in_ready: got %b want 0", in_ready_a); end
    checks++; if (out_data_a !== W'(8'hA1)) begin errors++; $display("FAIL skid_head_a: got %h want a1", out_data_a); end
    in_data = W'(8'hDD);
    tick();
    checks++; if (out_data_a !== W'(8'hA1) || out_wen_a !== 1'b1) begin errors++; $display("FAIL skid_stall_hold: got %h/%b want a1/1", out_data_a, out_wen_a); end
    checks++; if (occ_a !== 2'd2) begin errors++; $display("FAIL skid_stall_occ: got %0d want 2", occ_a); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (out_data_a !== W'(8'hB2) || out_valid_a !== 1'b1) begin errors++; $display("FAIL skid_head_b: got %h/%b want b2/1", out_data_a, out_valid_a); end
    checks++; if (out_wen_a !== 1'b0) begin errors++; $display("FAIL skid_wen_b: got %b want 0", out_wen_a); end
    tick();
    checks++; if (out_valid_a !== 1'b0 || occ_a !== 2'd0) begin errors++; $display("FAIL skid_drained: got v=%b occ=%0d want 0/0", out_valid_a, occ_a); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_wen = 1'b1;
    in_data = W'(8'h11); tick();
    in_data = W'(8'h22); tick();
    checks++; if (occ_a !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d want 2", occ_a); end
    flush = 1'b1; in_data = W'(8'h33);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid_a !== 1'b0 || out_wen_a !== 1'b0) begin errors++; $display("FAIL flush_outs: got v=%b wen=%b want 0/0", out_valid_a, out_wen_a); end
    checks++; if (occ_a !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occ_a); end
    checks++; if (out_data_a !== '0) begin errors++; $display("FAIL flush_cleared: got %h want 0", out_data_a); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL flush_c_absent: got %b want 0", out_valid_a); end
    // Flush in a cycle where the handshake would otherwise complete.
    out_ready = 1'b0; in_valid = 1'b1; in_data = W'(8'h44); tick();
    flush = 1'b1; in_data = W'(8'h55);
    #1;
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL flush_in_ready_prestate: got %b want 1", in_ready_a); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid_a !== 1'b0 || occ_a !== 2'd0) begin errors++; $display("FAIL flush_drop_accepted: got v=%b occ=%0d want 0/0", out_valid_a, occ_a); end
  endtask

  task automatic test_wen_gating();
    out_ready = 1'b1; in_valid = 1'b1; in_wen = 1'b1; in_data = W'(8'h77);
    tick();
    checks++; if (out_wen_a !== 1'b1 || out_data_a !== W'(8'h77)) begin errors++; $display("FAIL wen_on: got %b/%h want 1/77", out_wen_a, out_data_a); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_wen_a !== 1'b0 || out_valid_a !== 1'b0) begin errors++; $display("FAIL wen_bubble: got wen=%b v=%b want 0/0", out_wen_a, out_valid_a); end
    in_wen = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_wen = 1'b1;
    in_data = W'(8'h61); tick();
    in_data = W'(8'h62); tick();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    checks++; if (occ_a !== 2'd0 || out_valid_a !== 1'b0 || out_data_a !== '0) begin errors++; $display("FAIL reset_mid: got occ=%0d v=%b d=%h want 0/0/0", occ_a, out_valid_a, out_data_a); end
    tick();
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_mid_no_output: got %b want 0", out_valid_a); end
  endtask

  task automatic test_no_skid();
    rst = 1'b1; in_valid = 1'b0; in_wen = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0; in_valid = 1'b1; in_data = W'(12'h100);
    #1;
    checks++; if (in_ready_b !== 1'b1) begin errors++; $display("FAIL noskid_empty_ready: got %b want 1", in_ready_b); end
    tick();
    checks++; if (out_valid_b !== 1'b1 || out_data_b !== W'(12'h100)) begin errors++; $display("FAIL noskid_first: got %b/%h want 1/100", out_valid_b, out_data_b); end
    out_ready = 1'b1; in_data = W'(12'h101);
    #1;
    checks++; if (in_ready_b !== 1'b1) begin errors++; $display("FAIL noskid_passthru_ready: got %b want 1", in_ready_b); end
    tick();
    checks++; if (out_data_b !== W'(12'h101) || occ_b !== 2'd1) begin errors++; $display("FAIL noskid_tput1: got %h/%0d want 101/1", out_data_b, occ_b); end
    in_data = W'(12'h102);
    tick();
    checks++; if (out_data_b !== W'(12'h102)) begin errors++; $display("FAIL noskid_tput2: got %h want 102", out_data_b); end
    out_ready = 1'b0; in_data = W'(12'h103);
    #1;
    checks++; if (in_ready_b !== 1'b0) begin errors++; $display("FAIL noskid_stall_ready: got %b want 0", in_ready_b); end
    tick();
    checks++; if (out_data_b !== W'(12'h102) || occ_b !== 2'd1) begin errors++; $display("FAIL noskid_stall_hold: got %h/%0d want 102/1", out_data_b, occ_b); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_wen_gating();
    test_reset_mid();
    test_no_skid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
